// File: rtl/dot_product_ctrl_pkg.sv
// Shared types and widths for the dot-product controller and its accumulator.
package dot_product_ctrl_pkg;

    localparam int unsigned OPND_W = 32;
    localparam int unsigned PROD_W = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Operand pair as captured on an input transfer
    typedef struct packed {
        logic [OPND_W-1:0] a;
        logic [OPND_W-1:0] b;
        logic              last;
    } opnd_t;

endpackage

// File: rtl/dot_product_ctrl_acc.sv
// Dot-product accumulator: zero-extends each 64-bit product and sums modulo 2^ACC_W.
module dot_acc
    import dot_product_ctrl_pkg::*;
#(
    parameter int unsigned ACC_W = 72
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_clr,
    input  logic              i_add_en,
    input  logic [PROD_W-1:0] i_addend,
    output logic [ACC_W-1:0]  o_acc
);

    logic [ACC_W-1:0] r_acc;

    // Clear wins over add so a drained or aborted vector never leaks into the next
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (i_clr) begin
            r_acc <= '0;
        end else if (i_add_en) begin
            r_acc <= r_acc + ACC_W'(i_addend);
        end
    end

    assign o_acc = r_acc;

endmodule

// File: rtl/dot_product_ctrl.sv
// Dot-product sequencer: feeds operand pairs to an external 32x32 multiplier and sums products.
// Optional WAIT watchdog enabled by defining DOT_TIMEOUT_EN.
module dot_product_ctrl
    import dot_product_ctrl_pkg::*;
#(
    parameter int unsigned ACC_W       = 72,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OPND_W-1:0] a_in,
    input  logic [OPND_W-1:0] b_in,
    input  logic              in_last,
    output logic [OPND_W-1:0] mul_a,
    output logic [OPND_W-1:0] mul_b,
    output logic              mul_do,
    input  logic [PROD_W-1:0] mul_result,
    input  logic              mul_valid,
    output logic [ACC_W-1:0]  acc_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              err
);

    state_t           r_state;
    state_t           w_state_nxt;
    opnd_t            r_opnd;
    opnd_t            w_opnd_nxt;
    logic             r_in_ready;
    logic             w_in_ready_nxt;
    logic             r_mul_do;
    logic             w_mul_do_nxt;
    logic             r_out_valid;
    logic             w_out_valid_nxt;
    logic             w_acc_clr;
    logic             w_acc_add;
    logic [ACC_W-1:0] w_acc;

`ifdef DOT_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] r_tmo_cnt;
    logic [CNT_W-1:0] w_tmo_cnt_nxt;
    logic             r_err;
    logic             w_err_nxt;
`endif

    // Configurations with a narrower accumulator or a zero timeout are unsupported
    generate
        if (ACC_W < PROD_W || TIMEOUT_CYC == 0) begin : g_illegal_cfg
        end
    endgenerate

    // Next-state and registered-output decode
    always_comb begin
        w_state_nxt     = r_state;
        w_opnd_nxt      = r_opnd;
        w_in_ready_nxt  = 1'b0;
        w_mul_do_nxt    = 1'b0;
        w_out_valid_nxt = 1'b0;
        w_acc_clr       = 1'b0;
        w_acc_add       = 1'b0;
`ifdef DOT_TIMEOUT_EN
        w_tmo_cnt_nxt   = '0;
        w_err_nxt       = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                w_in_ready_nxt = 1'b1;
                if (in_valid && r_in_ready) begin
                    w_opnd_nxt     = '{a: a_in, b: b_in, last: in_last};
                    w_state_nxt    = ST_ISSUE;
                    w_in_ready_nxt = 1'b0;
                    w_mul_do_nxt   = 1'b1;
                end
            end
            ST_ISSUE: begin
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (mul_valid) begin
                    w_acc_add = 1'b1;
                    if (r_opnd.last) begin
                        w_state_nxt     = ST_DONE;
                        w_out_valid_nxt = 1'b1;
                    end else begin
                        w_state_nxt    = ST_IDLE;
                        w_in_ready_nxt = 1'b1;
                    end
                end
`ifdef DOT_TIMEOUT_EN
                else if (r_tmo_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                    w_acc_clr      = 1'b1;
                    w_err_nxt      = 1'b1;
                    w_state_nxt    = ST_IDLE;
                    w_in_ready_nxt = 1'b1;
                end else begin
                    w_tmo_cnt_nxt = r_tmo_cnt + CNT_W'(1);
                end
`endif
            end
            ST_DONE: begin
                w_out_valid_nxt = 1'b1;
                if (out_ready) begin
                    w_acc_clr       = 1'b1;
                    w_out_valid_nxt = 1'b0;
                    w_state_nxt     = ST_IDLE;
                    w_in_ready_nxt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_opnd      <= '0;
            r_in_ready  <= 1'b0;
            r_mul_do    <= 1'b0;
            r_out_valid <= 1'b0;
`ifdef DOT_TIMEOUT_EN
            r_tmo_cnt   <= '0;
            r_err       <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_opnd      <= w_opnd_nxt;
            r_in_ready  <= w_in_ready_nxt;
            r_mul_do    <= w_mul_do_nxt;
            r_out_valid <= w_out_valid_nxt;
`ifdef DOT_TIMEOUT_EN
            r_tmo_cnt   <= w_tmo_cnt_nxt;
            r_err       <= w_err_nxt;
`endif
        end
    end

    dot_acc #(
        .ACC_W (ACC_W)
    ) u_acc (
        .clk      (clk),
        .rst_n    (rst),
        .i_clr    (w_acc_clr),
        .i_add_en (w_acc_add),
        .i_addend (mul_result),
        .o_acc    (w_acc)
    );

    assign in_ready  = r_in_ready;
    assign mul_a     = r_opnd.a;
    assign mul_b     = r_opnd.b;
    assign mul_do    = r_mul_do;
    assign out_valid = r_out_valid;
    assign acc_out   = w_acc;

`ifdef DOT_TIMEOUT_EN
    assign err = r_err;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_dot_product_ctrl.sv
// Directed bench for dot_product_ctrl with a latency-programmable multiplier model and result scoreboard.
module tb_dot_product_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic        in_last;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic        mul_do;
    logic [63:0] mul_result;
    logic        mul_valid;
    logic [71:0] acc_out;
    logic        out_valid;
    logic        out_ready;
    logic        err;

    int n_checks = 0;
    int n_errors = 0;

    logic [71:0] exp_q[$];
    logic [71:0] exp_sum = '0;
    logic [71:0] last_exp = '0;

    // Multiplier model state
    logic        m_valid;
    logic [63:0] m_res;
    logic [63:0] m_prod;
    int          m_cnt;
    int          m_lat  = 5;
    bit          m_hold = 1'b0;
    logic        spur_valid;
    logic [63:0] spur_res;

    always #5 clk = ~clk;

    dot_product_ctrl #(
        .ACC_W       (72),
        .TIMEOUT_CYC (64)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a_in       (a_in),
        .b_in       (b_in),
        .in_last    (in_last),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_do     (mul_do),
        .mul_result (mul_result),
        .mul_valid  (mul_valid),
        .acc_out    (acc_out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .err        (err)
    );

    // External multiplier: answers each mul_do after m_lat cycles, unless held
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_valid <= 1'b0;
            m_res   <= '0;
            m_cnt    = 0;
        end else begin
            m_valid <= 1'b0;
            if (m_cnt > 0) begin
                m_cnt = m_cnt - 1;
                if (m_cnt == 0) begin
                    m_valid <= 1'b1;
                    m_res   <= m_prod;
                end
            end
            if (mul_do && !m_hold) begin
                m_cnt  = m_lat;
                m_prod = {32'b0, mul_a} * {32'b0, mul_b};
            end
        end
    end

    assign mul_valid  = m_valid | spur_valid;
    assign mul_result = spur_valid ? spur_res : m_res;

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_pair(input logic [31:0] a, input logic [31:0] b, input logic last);
        int n = 0;
        while (!in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_wait", 72'(n < 300), 72'd1);
        in_valid = 1'b1;
        a_in     = a;
        b_in     = b;
        in_last  = last;
        exp_sum  = exp_sum + ({40'b0, a} * {40'b0, b});
        if (last) begin
            exp_q.push_back(exp_sum);
            exp_sum = '0;
        end
        @(negedge clk);
        in_valid = 1'b0;
        check("mul_do_issue", 72'(mul_do), 72'd1);
        check("mul_ab_issue", {8'b0, mul_a, mul_b}, {8'b0, a, b});
        @(negedge clk);
        check("mul_do_pulse", 72'(mul_do), 72'd0);
    endtask

    task automatic collect(input string tag);
        int n = 0;
        while (!mul_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_mulvalid_wait"}, 72'(n < 300), 72'd1);
        @(negedge clk);
        check({tag, "_out_valid"}, 72'(out_valid), 72'd1);
        last_exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        check({tag, "_acc_out"}, acc_out, last_exp);
        check({tag, "_in_ready_done"}, 72'(in_ready), 72'd0);
    endtask

    task automatic release_out(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_drained"}, {70'b0, out_valid, in_ready}, 72'b01);
        check({tag, "_acc_cleared"}, acc_out, 72'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed=no_finish expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst        = 1'b0;
        in_valid   = 1'b0;
        a_in       = '0;
        b_in       = '0;
        in_last    = 1'b0;
        out_ready  = 1'b0;
        spur_valid = 1'b0;
        spur_res   = '0;
        repeat (3) @(negedge clk);
        check("reset_ctrl", {68'b0, in_ready, mul_do, out_valid, err}, 72'd0);
        check("reset_ab", {8'b0, mul_a, mul_b}, 72'd0);
        check("reset_acc", acc_out, 72'd0);
        rst = 1'b1;
        @(negedge clk);
        check("idle_in_ready", 72'(in_ready), 72'd1);

        // Three-term vector, then consumer stall
        send_pair(32'd3, 32'd4, 1'b0);
        send_pair(32'd5, 32'd6, 1'b0);
        send_pair(32'd7, 32'd8, 1'b1);
        collect("vec98");
        check("vec98_const", acc_out, 72'd98);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("stall_hold", {acc_out[69:0], out_valid, in_ready}, {last_exp[69:0], 2'b10});
        end
        release_out("vec98");

        // Product strobe while idle must not reach the accumulator
        spur_valid = 1'b1;
        spur_res   = 64'd1000;
        @(negedge clk);
        spur_valid = 1'b0;
        check("spurious_acc", acc_out, 72'd0);
        send_pair(32'd2, 32'd3, 1'b1);
        collect("vec6");
        release_out("vec6");

        // Largest single product
        send_pair(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        collect("max1");
        check("max1_const", acc_out, 72'h00_FFFF_FFFE_0000_0001);
        release_out("max1");

        // 256 largest products need the carry bits above 64
        m_lat = 1;
        for (int i = 0; i < 256; i++) begin
            send_pair(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'(i == 255));
        end
        collect("max256");
        check("max256_const", acc_out, 72'hFF_FFFF_FE00_0000_0100);
        release_out("max256");

        // Random operands with varying multiplier latency
        for (int i = 0; i < 12; i++) begin
            m_lat = int'($urandom_range(1, 8));
            send_pair($urandom, $urandom, 1'(i == 11));
        end
        collect("rand");
        release_out("rand");
        m_lat = 5;

        // Reset while waiting on the second product
        send_pair(32'd9, 32'd9, 1'b0);
        send_pair(32'd10, 32'd10, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        check("midrst_ctrl", {68'b0, in_ready, mul_do, out_valid, err}, 72'd0);
        check("midrst_ab", {8'b0, mul_a, mul_b}, 72'd0);
        check("midrst_acc", acc_out, 72'd0);
        exp_sum = '0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        send_pair(32'd2, 32'd2, 1'b1);
        collect("post_rst");
        check("post_rst_const", acc_out, 72'd4);
        release_out("post_rst");

        // Multiplier that never answers
        m_hold = 1'b1;
        send_pair(32'd1, 32'd1, 1'b1);
        void'(exp_q.pop_back());
`ifdef DOT_TIMEOUT_EN
        repeat (63) @(negedge clk);
        check("tmo_early", 72'(err), 72'd0);
        @(negedge clk);
        check("tmo_pulse", {69'b0, err, in_ready, out_valid}, 72'b110);
        check("tmo_acc", acc_out, 72'd0);
        @(negedge clk);
        check("tmo_one_cycle", 72'(err), 72'd0);
        m_hold = 1'b0;
`else
        repeat (100) @(negedge clk);
        check("no_tmo_stuck", {69'b0, err, in_ready, out_valid}, 72'd0);
        rst = 1'b0;
        @(negedge clk);
        rst    = 1'b1;
        m_hold = 1'b0;
        @(negedge clk);
        check("no_tmo_recover", 72'(in_ready), 72'd1);
`endif

        check("scoreboard_empty", 72'(exp_q.size()), 72'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dot_product_ctrl.md
DOT_PRODUCT_CTRL -- requirements
Module: dot_product_ctrl

Interface
REQ-001 SHALL have parameter ACC_W, default 72, accumulator/result width (>=64).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 64, cycles allowed between mul_do and mul_valid.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  operand pair available.
REQ-006 SHALL have port in_ready  output  1  block accepts operand pair.
REQ-007 SHALL have ports a_in, b_in  input  32 each  unsigned operands.
REQ-008 SHALL have port in_last  input  1  pair is final term of the vector.
REQ-009 SHALL have ports mul_a, mul_b  output  32 each  operands to the 32x32 multiplier.
REQ-010 SHALL have port mul_do  output  1  one-cycle start pulse to the multiplier.
REQ-011 SHALL have port mul_result  input  64  multiplier product.
REQ-012 SHALL have port mul_valid  input  1  product valid.
REQ-013 SHALL have port acc_out  output  ACC_W  dot-product result.
REQ-014 SHALL have port out_valid  output  1  acc_out valid; out_ready  input  1  consumer accepts.
REQ-015 SHALL have port err  output  1  one-cycle timeout pulse.

Function
REQ-016 SHALL implement FSM IDLE, ISSUE, WAIT, DONE; reset state IDLE.
REQ-017 in_ready SHALL be 1 only in IDLE; transfer when in_valid && in_ready.
REQ-018 On transfer SHALL register a_in, b_in, in_last onto mul_a, mul_b, last flag; go to ISSUE.
REQ-019 In ISSUE SHALL drive mul_do=1 for exactly one cycle, then go to WAIT.
REQ-020 mul_a/mul_b SHALL stay stable from ISSUE until mul_valid is sampled.
REQ-021 In WAIT, first cycle mul_valid=1 SHALL add zero-extended mul_result to accumulator (mod 2^ACC_W).
REQ-022 After add: last flag=0 -> IDLE; last flag=1 -> DONE.
REQ-023 mul_valid outside WAIT SHALL be ignored.
REQ-024 In DONE SHALL hold out_valid=1, acc_out stable until out_ready=1; on that edge clear accumulator, go to IDLE.
REQ-025 Latency in_valid accept to mul_do = 1 cycle; final mul_valid to out_valid = 1 cycle.
REQ-026 Single-term vector (in_last=1 on first pair) SHALL produce acc_out = a*b.

Reset
REQ-027 rst=0 SHALL immediately force: state IDLE, accumulator 0, acc_out 0, mul_a/mul_b 0, mul_do 0, out_valid 0, err 0, in_ready 0 while asserted.
REQ-028 Reset mid-vector SHALL discard partial sum; first transfer after release starts a new vector.

Configuration
REQ-029 With DOT_TIMEOUT_EN defined, a counter SHALL run in WAIT; reaching TIMEOUT_CYC without mul_valid pulses err for one cycle, clears accumulator, returns to IDLE.
REQ-030 Without DOT_TIMEOUT_EN, WAIT SHALL persist indefinitely, err tied 0, no counter logic.

Structure
REQ-031 Shared package SHALL hold FSM state enum, operand width 32, product width 64.
REQ-032 Accumulator SHALL be a sub-module dot_acc (clear, add-enable, 64-bit input, ACC_W output).

Verification
REQ-033 Pairs (3,4),(5,6),(7,8,last) with multiplier model latency 5 -> acc_out=98, out_valid 1 cycle after third mul_valid.
REQ-034 Single pair (FFFFFFFF,FFFFFFFF,last) -> acc_out=FFFFFFFE00000001.
REQ-035 256 pairs of FFFFFFFF -> acc_out=256*FFFFFFFE00000001 without loss (72 bits).
REQ-036 out_ready held 0 for 10 cycles -> out_valid, acc_out stable; in_ready=0 throughout.
REQ-037 rst pulled low during WAIT of term 2 -> all outputs 0 at once; next vector (2,2,last) -> acc_out=4.
REQ-038 DOT_TIMEOUT_EN defined, mul_valid never returned -> err pulse 64 cycles after WAIT entry, state IDLE, in_ready=1.
